// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RISC-V core.
// Combines load-use hazards, taken branches resolved in EX and multi-cycle
// data-memory accesses into the stall/enable/flush controls of the pipeline
// registers. A two-state wait FSM freezes the pipe while memory is busy,
// aborts the access after MEM_TIMEOUT cycles and raises a sticky error flag.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,  // legal range 2..255
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             ErrClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             EnM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       freeze, abort, load_use;

  // Classify the current cycle: memory freeze, memory abort, load-use hazard.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    freeze   = 1'b0;
    abort    = 1'b0;
    load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    if (state == RUN) begin
      freeze = MemReqM && !MemReadyM;
    end else if (!MemReadyM) begin
      freeze = (wait_cnt < TIMEOUT);
      abort  = (wait_cnt == TIMEOUT);
    end
  end

  // Next state and wait counter: enter/extend WAIT on freeze, leave on ready or abort.
  always_comb begin
    state_nxt    = RUN;
    wait_cnt_nxt = 8'd0;
    if (freeze) begin
      state_nxt    = WAIT;
      wait_cnt_nxt = (state == WAIT) ? wait_cnt + 8'd1 : 8'd1;
    end
  end

  // Pipeline controls by priority freeze/abort > branch > load-use; idle during reset.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    EnM    = 1'b1;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        EnM    = 1'b0;
        FlushW = 1'b1;
      end else if (abort) begin
        FlushM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // A branch squashes the hazard-carrying instruction anyway, so no stall.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every control register is cleared by the async reset, so the
    // pipe comes out of reset idle; state uses non-blocking assignments so
    // all registers update together on the edge.
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag; a new abort outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemErr <= 1'b0;
    end else if (abort) begin
      MemErr <= 1'b1;
    end else if (ErrClr) begin
      MemErr <= 1'b0;
    end
  end

  // Saturating count of fetch-stall cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles <= '0;
    end else if (StallF && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int T = 4;
  localparam int W = 16;
  localparam int CNT_MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   Rs1D, Rs2D, RdE;
  logic         MemReadE, PCSrcE, MemReqM, MemReadyM, ErrClr;
  logic         StallF, StallD, StallE, EnM, FlushD, FlushE, FlushM, FlushW, MemErr;
  logic [W-1:0] StallCycles;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .ErrClr(ErrClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .EnM(EnM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MemErr(MemErr), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: whether an access is outstanding, how many cycles it
  // has been frozen so far, the error flag and the stall-cycle tally.
  bit m_busy;
  int m_waited;
  bit m_err;
  int m_cnt;

  // Control vector order: StallF StallD StallE EnM FlushD FlushE FlushM FlushW
  localparam logic [7:0] IDLE = 8'b0001_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctl_now();
    return {StallF, StallD, StallE, EnM, FlushD, FlushE, FlushM, FlushW};
  endfunction

  // Expected controls from the rules; reports whether this is a freeze or abort cycle.
  function automatic logic [7:0] model_ctl(output bit fr, output bit ab);
    bit lu;
    fr = 1'b0;
    ab = 1'b0;
    if (!m_busy) fr = MemReqM && !MemReadyM;
    else if (!MemReadyM) begin
      if (m_waited < T) fr = 1'b1;
      else              ab = 1'b1;
    end
    lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (fr)          return 8'b1110_0001;
    else if (ab)     return 8'b0001_0011;
    else if (PCSrcE) return 8'b0001_1100;
    else if (lu)     return 8'b1101_0100;
    return IDLE;
  endfunction

  // One clock: evaluate at the falling edge, optionally compare, advance model.
  task automatic cycle(input bit chk, input string tag);
    logic [7:0] e;
    bit fr, ab;
    @(negedge clk);
    e = model_ctl(fr, ab);
    if (chk) begin
      check({tag, "/ctl"}, 32'(ctl_now()), 32'(e));
      check({tag, "/err"}, 32'(MemErr), 32'(m_err));
      check({tag, "/cnt"}, 32'(StallCycles), 32'(m_cnt));
    end
    if (fr) begin
      m_waited = m_busy ? m_waited + 1 : 1;
      m_busy   = 1'b1;
    end else begin
      m_busy   = 1'b0;
      m_waited = 0;
    end
    if (ab)          m_err = 1'b1;
    else if (ErrClr) m_err = 1'b0;
    if (e[7] && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    Rs1D = 0; Rs2D = 0; RdE = 0;
    MemReadE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0; ErrClr = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_err = 0; m_cnt = 0;
  endtask

  initial begin
    // Reset with a load-use hazard on the inputs: outputs must stay idle.
    quiet();
    model_reset();
    rst = 1'b0;
    MemReadE = 1; RdE = 5'd7; Rs1D = 5'd7;
    #12;
    check("rst/ctl", 32'(ctl_now()), 32'(IDLE));
    check("rst/err", 32'(MemErr), 32'd0);
    check("rst/cnt", 32'(StallCycles), 32'd0);
    quiet();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on Rs2D, then the load leaves EX.
    MemReadE = 1; RdE = 5'd5; Rs2D = 5'd5;
    cycle(1, "lu");
    quiet();
    cycle(1, "lu_after");
    check("lu_cnt", 32'(StallCycles), 32'd1);
    // Same match but with x0 as destination: no hazard.
    MemReadE = 1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    cycle(1, "lu_x0");
    // Branch together with a load-use: flush only.
    MemReadE = 1; RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1;
    cycle(1, "br_lu");
    check("br_lu_cnt", 32'(StallCycles), 32'd1);
    quiet();

    // Memory access with ready three cycles late.
    MemReqM = 1;
    for (int k = 1; k <= 3; k++) begin
      cycle(1, "mw_frz");
      check("mw_waitcnt", 32'(dut.wait_cnt), 32'(k));
    end
    MemReadyM = 1;
    cycle(1, "mw_rel");
    check("mw_waitcnt0", 32'(dut.wait_cnt), 32'd0);
    quiet();
    cycle(1, "mw_idle");

    // Timeout: ready never comes; abort after T frozen cycles.
    MemReqM = 1;
    for (int k = 0; k < T; k++) cycle(1, "to_frz");
    cycle(1, "to_abort");
    check("to_err_set", 32'(MemErr), 32'd1);
    MemReqM = 0; ErrClr = 1;
    cycle(1, "to_clr");
    check("to_err_clr", 32'(MemErr), 32'd0);
    quiet();

    // Branch during freeze is suppressed, then honoured in the release cycle.
    MemReqM = 1; PCSrcE = 1;
    cycle(1, "bf_frz0");
    cycle(1, "bf_frz1");
    MemReadyM = 1;
    cycle(1, "bf_rel");
    quiet();

    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 400; i++) begin
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      RdE       = 5'($urandom_range(0, 3));
      MemReadE  = ($urandom_range(0, 2) == 0);
      PCSrcE    = ($urandom_range(0, 4) == 0);
      MemReqM   = ($urandom_range(0, 1) == 0);
      MemReadyM = ($urandom_range(0, 3) == 0);
      ErrClr    = ($urandom_range(0, 9) == 0);
      cycle(1, "rnd");
    end
    quiet();
    cycle(1, "rnd_end");

    // Reset asserted mid-WAIT: immediate idle, registers cleared, no error.
    MemReqM = 1;
    cycle(1, "rw_frz0");
    cycle(1, "rw_frz1");
    #2;
    rst = 1'b0;
    #1;
    check("rw/ctl", 32'(ctl_now()), 32'(IDLE));
    check("rw/err", 32'(MemErr), 32'd0);
    check("rw/cnt", 32'(StallCycles), 32'd0);
    check("rw/waitcnt", 32'(dut.wait_cnt), 32'd0);
    model_reset();
    quiet();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, "rw_after");

    // Saturation: hold a load-use hazard well past 2^W cycles.
    MemReadE = 1; RdE = 5'd3; Rs1D = 5'd3;
    for (int i = 0; i < 70000; i++) cycle(0, "sat");
    cycle(1, "sat_end");
    check("sat_cnt", 32'(StallCycles), 32'(CNT_MAX));
    quiet();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the stall, enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from three sources: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory accesses. A registered wait FSM freezes the pipe during memory access, aborts on timeout, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MEM_TIMEOUT, 16, maximum freeze cycles for one memory access; legal range 2..255
- CNT_W, 16, width of stall-cycle counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1D  in  5  source register 1 of the instruction in ID
- Rs2D  in  5  source register 2 of the instruction in ID
- RdE  in  5  destination register of the instruction in EX
- MemReadE  in  1  instruction in EX is a load
- PCSrcE  in  1  branch taken / jump in EX
- MemReqM  in  1  instruction in MEM accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- ErrClr  in  1  synchronous clear of MemErr
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- EnM  out  1  EX/MEM load enable (0 = hold)
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX
- FlushM  out  1  clear EX/MEM
- FlushW  out  1  clear MEM/WB (insert bubble)
- MemErr  out  1  sticky memory-timeout flag
- StallCycles  out  CNT_W  saturating count of cycles with StallF=1

## Operation
- FSM state register: RUN, WAIT. WaitCnt is an 8-bit register.
- Control outputs are combinational from the inputs and the registered state. State, WaitCnt, MemErr and StallCycles are registered.
- Freeze condition:
  - In RUN: MemReqM & !MemReadyM.
  - In WAIT: !MemReadyM & WaitCnt < MEM_TIMEOUT.
- Freeze outputs: StallF=StallD=StallE=1, EnM=0, FlushW=1. All other flushes are 0.
- Abort condition, WAIT only: !MemReadyM & WaitCnt == MEM_TIMEOUT.
  - Outputs: FlushM=1, FlushW=1, EnM=1. All stalls are 0.
  - Next state RUN; MemErr set to 1.
- Load-use condition: MemReadE & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
  - Outputs: StallF=StallD=1, FlushE=1. One cycle only; it self-clears once the load moves to MEM.
- Branch condition: PCSrcE. Outputs: FlushD=1, FlushE=1.
- Priority: freeze/abort > branch > load-use.
  - Branch and load-use together: flush only, no StallF/StallD.
  - Branch or load-use during freeze: suppressed; re-evaluated after release because all upstream registers hold.
- Idle (no condition active): StallF=StallD=StallE=0, EnM=1, all flushes 0.
- Transitions:
  - RUN→WAIT on freeze, WaitCnt←1.
  - WAIT→WAIT on freeze, WaitCnt+1.
  - WAIT→RUN on MemReadyM; that cycle is idle/normal with EnM=1, and WaitCnt←0.
  - WAIT→RUN on abort, WaitCnt←0.
- MemErr: set on abort, cleared by ErrClr. If set and clear occur in the same cycle, set wins.
- StallCycles increments when StallF=1 and saturates at all-ones.

## Timing
- Reset (rst=0, async) values:
  - State RUN, WaitCnt 0, MemErr 0, StallCycles 0.
  - While rst=0, all stall/flush outputs are 0 and EnM=1.
- Hazard response latency is 0 cycles (combinational). Registered effects appear on the next rising edge.
- A memory access with ready at cycle t (RUN): no freeze.
- A memory access with first ready at cycle t+k (1 ≤ k ≤ MEM_TIMEOUT): freeze for cycles t..t+k-1, release at t+k.
- No ready at all: freeze for cycles t..t+MEM_TIMEOUT-1, abort at t+MEM_TIMEOUT.
- Back-to-back accesses: after release, a new MemReqM & !MemReadyM in RUN re-enters WAIT immediately.
- Reset asserted mid-WAIT: FSM returns to RUN asynchronously; no abort, MemErr stays 0.

## Test plan
- Load-use: MemReadE=1, RdE=5, Rs2D=5 → one cycle of StallF=StallD=FlushE=1, StallCycles=1. Repeat with RdE=0 → no stall.
- Branch plus load-use in the same cycle: PCSrcE=1 with the hazard active → FlushD=FlushE=1, StallF=0, StallCycles unchanged.
- Memory wait: MemReqM=1 at t, MemReadyM=1 at t+3 → freeze for 3 cycles (EnM=0, FlushW=1), state WAIT with WaitCnt 1..3, then RUN with EnM=1 at t+3.
- Timeout (MEM_TIMEOUT=4): MemReqM=1 with ready never asserted → freeze t..t+3, abort at t+4 (FlushM=FlushW=1), MemErr=1. ErrClr=1 → MemErr=0.
- Branch during freeze: PCSrcE=1 during WAIT → FlushD/FlushE stay 0; after release, PCSrcE still high → flush in the release cycle.
- Counter and reset: force 70000 stall cycles with CNT_W=16 → StallCycles=65535. rst=0 mid-WAIT → outputs idle immediately, all registers at reset values.
